// File: rtl/noc_input_fifo_if.sv
// Handshake and head-of-queue bundle between one router input port, its
// upstream sender (RTS/CTS) and the five output arbiters (read enables).
// "master" is the environment side (sender plus arbiters); "slave" is the FIFO.
interface noc_input_fifo_if #(
  parameter int DATA_WIDTH = 32
);

  // Upstream flit and its request-to-send
  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  // Clear-to-send pulse back to the upstream sender
  logic                  CTS;

  // Grants from the five output arbiters; any of them pops the head flit
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;

  // Head flit and occupancy flags towards routing logic and crossbar
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;

  modport master (
    output RX, DRTS,
    output read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full
  );

  modport slave (
    input  RX, DRTS,
    input  read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full
  );

endinterface : noc_input_fifo_if

// File: rtl/noc_input_fifo.sv
// Per-direction input buffer of the NoC router. Flits arrive over a one-flit
// RTS/CTS handshake, are kept in a circular buffer, and the head flit is shown
// combinationally to routing and crossbar. Any arbiter grant pops the head.
// The interface DATA_WIDTH must match this module's DATA_WIDTH.
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  noc_input_fifo_if.slave  s_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_read_ptr;
  logic [PTR_W-1:0]      r_write_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_cts;

  // Combinational control
  logic                  w_empty;
  logic                  w_full;
  logic                  w_read_req;
  logic                  w_read_fire;
  logic                  w_write_en;
  logic [CNT_W-1:0]      w_count_next;

  // Occupancy flags and the accept/pop decisions for this cycle.
  // full is taken from the registered count, so a pop in the same cycle does
  // not open a slot for a write until the following cycle. A write is also
  // refused while CTS is high so a sender still dropping RTS is not captured twice.
  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == DEPTH_C);
    w_read_req  = s_if.read_en_N | s_if.read_en_E | s_if.read_en_W |
                  s_if.read_en_S | s_if.read_en_L;
    w_read_fire = w_read_req & ~w_empty;
    w_write_en  = s_if.DRTS & ~r_cts & ~w_full;
  end

  // Next occupancy: several grants at once still remove only one flit.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    w_count_next = r_count;
    unique case ({w_write_en, w_read_fire})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, count and the one-cycle CTS pulse; reset discards all flits.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_read_ptr  <= '0;
      r_write_ptr <= '0;
      r_count     <= '0;
      r_cts       <= 1'b0;
    end else begin
      if (w_write_en) begin
        r_write_ptr <= r_write_ptr + PTR_W'(1);
      end
      if (w_read_fire) begin
        r_read_ptr <= r_read_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      // High exactly in the cycle after an accepted flit, never two in a row
      // because w_write_en is blocked while r_cts is set.
      r_cts   <= w_write_en;
    end
  end

  // Flit storage written at the tail pointer.
  always_ff @(posedge clk) begin
    // NOTE: buffer memories are normally left unreset; these slots are cleared
    // because Data_out is an unqualified read of the head slot and must show 0
    // after reset, which keeps this storage in flops rather than a RAM macro.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write_en) begin
      r_mem[r_write_ptr] <= s_if.RX;
    end
  end

  // Outputs: head slot is always visible, stale while empty.
  assign s_if.Data_out = r_mem[r_read_ptr];
  assign s_if.empty    = w_empty;
  assign s_if.full     = w_full;
  assign s_if.CTS      = r_cts;

endmodule : noc_input_fifo

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed test-plan sequences plus a
// randomized RTS/CTS sender and random arbiter grants. A queue-based reference
// model predicts accepted flits; a monitor compares every pop and the flags.
module tb_noc_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  noc_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted flits, an occupancy level and the
  // CTS pulse, derived directly from the handshake rules.
  logic [DW-1:0] sb_q[$];
  int            m_level = 0;
  logic          m_cts   = 1'b0;
  logic          m_req;
  logic          m_wr;
  logic          m_rd;

  assign m_req = bus.read_en_N | bus.read_en_E | bus.read_en_W | bus.read_en_S | bus.read_en_L;
  assign m_wr  = bus.DRTS && !m_cts && (m_level < DEPTH);
  assign m_rd  = m_req && (m_level > 0);

  always @(posedge clk) begin
    if (rst) begin
      m_level <= 0;
      m_cts   <= 1'b0;
      sb_q.delete();
    end else begin
      m_level <= m_level + int'(m_wr) - int'(m_rd);
      m_cts   <= m_wr;
      if (m_wr) sb_q.push_back(bus.RX);
    end
  end

  // Monitor: on the falling edge compare flags with the model, and whenever the
  // DUT is about to pop, compare the head flit with the oldest expected flit.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      check("cts_flag", bus.CTS, m_cts);
      check("empty_flag", bus.empty, (m_level == 0));
      check("full_flag", bus.full, (m_level == DEPTH));
      if (!rst && m_req && !bus.empty) begin
        if (sb_q.size() == 0) check("pop_underflow", bus.empty, 1'b1);
        else                  check("pop_data", bus.Data_out, sb_q.pop_front());
      end
    end
  end

  // Advance one cycle; inputs change 1 ns after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reads(input logic [4:0] v);
    {bus.read_en_N, bus.read_en_E, bus.read_en_W, bus.read_en_S, bus.read_en_L} = v;
  endtask

  // Full sender handshake; returns in the cycle CTS is high with RTS dropped.
  task automatic send_flit(input logic [DW-1:0] d);
    int n = 0;
    bus.DRTS = 1'b1;
    bus.RX   = d;
    do begin
      step();
      n++;
    end while (!bus.CTS && n < 64);
    if (!bus.CTS) check("cts_timeout", bus.CTS, 1'b1);
    bus.DRTS = 1'b0;
  endtask

  task automatic pop_one();
    set_reads(5'b00010);
    step();
    set_reads(5'b00000);
  endtask

  task automatic drain();
    int n = 0;
    set_reads(5'b00100);
    while (m_level > 0 && n < 64) begin
      step();
      n++;
    end
    set_reads(5'b00000);
    check("drain_empty", bus.empty, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with RTS already raised: nothing may be accepted during reset
    rst      = 1'b1;
    bus.DRTS = 1'b1;
    bus.RX   = 32'hA5A5_0001;
    set_reads(5'b00000);
    step();
    mon_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_cts", bus.CTS, 1'b0);
      check("rst_empty", bus.empty, 1'b1);
      check("rst_full", bus.full, 1'b0);
      check("rst_data", bus.Data_out, 32'h0);
      if (i == 0) step();
    end
    rst = 1'b0;

    // First handshake right after reset; RX/RTS held one extra cycle
    step();
    check("hs_cts", bus.CTS, 1'b1);
    check("hs_data", bus.Data_out, 32'hA5A5_0001);
    check("hs_empty", bus.empty, 1'b0);
    step();
    check("hs_cts_drop", bus.CTS, 1'b0);
    bus.DRTS = 1'b0;
    step();
    pop_one();
    check("hs_single", bus.empty, 1'b1);

    // Fill to full, hold a fifth request, then free one slot
    for (int i = 1; i <= 4; i++) send_flit(DW'(i));
    check("fill_full", bus.full, 1'b1);
    bus.DRTS = 1'b1;
    bus.RX   = 32'h5;
    for (int i = 0; i < 10; i++) begin
      step();
      check("full_hold_cts", bus.CTS, 1'b0);
    end
    check("full_head", bus.Data_out, 32'h1);
    set_reads(5'b01000);
    step();
    set_reads(5'b00000);
    check("full_pop_head", bus.Data_out, 32'h2);
    check("full_pop_cts", bus.CTS, 1'b0);
    step();
    check("fifth_cts", bus.CTS, 1'b1);
    bus.DRTS = 1'b0;
    check("fifth_full", bus.full, 1'b1);
    drain();

    // Wrap-around: 10 flits interleaved with pops
    for (int i = 0; i < 10; i++) begin
      send_flit(DW'(32'h10 + i));
      if (i > 0) pop_one();
    end
    drain();

    // Simultaneous write and read at level 2
    send_flit(32'h20);
    send_flit(32'h21);
    step();
    bus.DRTS = 1'b1;
    bus.RX   = 32'h22;
    set_reads(5'b10000);
    step();
    set_reads(5'b00000);
    bus.DRTS = 1'b0;
    check("simul_cts", bus.CTS, 1'b1);
    check("simul_head", bus.Data_out, 32'h21);
    pop_one();
    check("simul_head2", bus.Data_out, 32'h22);
    pop_one();
    check("simul_level2", bus.empty, 1'b1);

    // Read request while empty leaves pointers alone
    set_reads(5'b00001);
    step(3);
    set_reads(5'b00000);
    check("rd_empty", bus.empty, 1'b1);
    send_flit(32'h30);
    check("rd_empty_ptr", bus.Data_out, 32'h30);
    drain();

    // Two grants together remove one flit
    send_flit(32'h40);
    send_flit(32'h41);
    send_flit(32'h42);
    set_reads(5'b11000);
    step();
    set_reads(5'b00000);
    check("dual_head", bus.Data_out, 32'h41);
    pop_one();
    check("dual_head2", bus.Data_out, 32'h42);
    pop_one();
    check("dual_empty", bus.empty, 1'b1);

    // Reset mid-operation: level 3 with CTS high
    send_flit(32'h50);
    send_flit(32'h51);
    send_flit(32'h52);
    check("mid_cts", bus.CTS, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_empty", bus.empty, 1'b1);
    check("mid_cts0", bus.CTS, 1'b0);
    check("mid_data", bus.Data_out, 32'h0);
    send_flit(32'h53);
    check("mid_after", bus.Data_out, 32'h53);
    drain();

    // Random phase: protocol-following sender, random (possibly multi-hot) grants
    begin
      int gap = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (bus.DRTS && bus.CTS) begin
          bus.DRTS = 1'b0;
          gap = $urandom_range(0, 3);
        end else if (!bus.DRTS) begin
          if (gap == 0) begin
            bus.DRTS = 1'b1;
            bus.RX   = $urandom;
          end else begin
            gap--;
          end
        end
        if ($urandom_range(0, 99) < (((cyc / 500) % 2 == 1) ? 15 : 60))
          set_reads(5'($urandom_range(1, 31)));
        else
          set_reads(5'b00000);
        step();
      end
      bus.DRTS = 1'b0;
      set_reads(5'b00000);
      step(2);
      drain();
    end

    check("final_queue", 32'(sb_q.size()), 32'h0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_noc_input_fifo

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
- Per-port input buffer of the NoC router; one instance per input direction (N, E, W, S, L).
- Accepts flits from the upstream router/NI over the RTS/CTS one-flit handshake.
- Stores flits in a circular buffer and presents the head flit to the routing logic and crossbar.
- Pops the head flit when any output arbiter grants this input; the grants arrive as read enables.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of flit slots; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- RX  input  DATA_WIDTH  flit from the upstream router/NI.
- DRTS  input  1  upstream RTS; RX is valid while high.
- CTS  output  1  clear-to-send pulse to upstream; at most 1 cycle wide.
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  grants from the five output arbiters; each requests a pop.
- Data_out  output  DATA_WIDTH  head flit; combinational read of mem[read_ptr].
- empty  output  1  high when the buffer holds no flit.
- full  output  1  high when count == DEPTH.

Behaviour:
- Reset: clk, rst as above (one clock, synchronous, active-high).
  - On reset: read_ptr = 0, write_ptr = 0, count = 0, CTS = 0, all mem slots = 0.
  - So after reset: empty = 1, full = 0, Data_out = 0.
  - Reset overrides any simultaneous write or read in that cycle; buffered flits are discarded.
- Write handshake:
  - write_en = DRTS & ~CTS & ~full, evaluated combinationally in cycle t.
  - On write_en at edge t: mem[write_ptr] <= RX, write_ptr increments, and CTS is 1 during cycle t+1.
  - CTS returns to 0 at edge t+1 unconditionally; it is never high for two consecutive cycles.
  - While CTS = 1, no write occurs even if DRTS is still high. This prevents a double capture while the sender drops RTS.
  - DRTS high while full: no write, CTS stays 0. The sender holds RTS and RX stable until space frees.
  - Minimum spacing between accepted flits is 2 cycles, matching the sender's RTS low/high turnaround.
- Read:
  - read_req = OR of the five read_en_* inputs.
  - read_fire = read_req & ~empty.
  - On read_fire, read_ptr increments at the edge.
  - Several read_en_* high at once count as one pop; this is a protocol error upstream, and no assertion is raised in the block.
  - A read_req while empty is ignored; pointers and count are unchanged.
  - Data_out always shows mem[read_ptr], including while empty (stale data); consumers qualify it with empty.
- Count and pointers:
  - count next = count + write_en − read_fire; width clog2(DEPTH)+1 bits.
  - Pointers are clog2(DEPTH) bits and wrap from DEPTH−1 to 0 naturally.
  - empty = (count == 0); full = (count == DEPTH).
- Simultaneous events:
  - Write and read in the same cycle, not empty and not full: count unchanged, both pointers advance.
  - Write into an empty FIFO: the flit is visible on Data_out and empty = 0 from cycle t+1. There is no same-cycle bypass.
  - Full with a read this cycle: write_en is still blocked this cycle because full is evaluated before the pop. The write is accepted in the next cycle if DRTS is still high.
- Latency: flit accepted at edge t is poppable at edge t+1 at the earliest.

Test Plan:
- Reset then idle: assert rst 2 cycles with DRTS = 1 → CTS = 0, empty = 1, full = 0, Data_out = 0 throughout reset; first CTS pulse occurs in the cycle after rst drops.
- Single-flit handshake: DRTS = 1, RX = 0xA5A5_0001 at cycle t → CTS = 1 only in t+1; Data_out = 0xA5A5_0001 and empty = 0 at t+1; RX held one extra cycle is not written twice (count = 1).
- Fill to full (DEPTH = 4):
  - Send 0x1..0x4 with the RTS/CTS protocol → full = 1 after the 4th flit.
  - A 5th DRTS is held with CTS = 0 for 10 cycles.
  - Pulse read_en_E once → Data_out goes 0x1 → 0x2; the 5th flit is accepted 1 cycle later; its CTS pulse follows.
- Wrap-around: push/pop 10 flits 0x10..0x19, interleaved so pointers wrap twice → Data_out order is exactly 0x10..0x19; empty = 1 at the end.
- Simultaneous read and write at count = 2 → count stays 2, order preserved.
- Read while empty: read_en_L = 1 → pointers unchanged.
- Two read_en_* high together with count = 3 → count = 2, one pop.
- Reset mid-operation: count = 3 with CTS = 1 when rst asserts → next cycle count = 0, empty = 1, CTS = 0, Data_out = 0; the following DRTS is handshaken normally.
